// File: rtl/alu_seq_handshake.sv
// WIDTH-bit sequential ALU with valid/ready handshakes on input and output.
// Single-cycle ops finish in one clock; MUL/DIV iterate one bit per clock.
module alu_seq_handshake #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           Opcode,
   input  logic [WIDTH-1:0]     Operand1,
   input  logic [WIDTH-1:0]     Operand2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   Result,
   output logic                 flagC,
   output logic                 flagZ
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_DONE
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 flag_c_q, flag_c_d;
   logic                 flag_z_q, flag_z_d;

   logic [2*WIDTH-1:0]   alu_res;
   logic                 alu_c;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step_res;
   logic                 step_c;

   // Single-cycle operations, evaluated directly on the incoming operands.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      add_sum = {1'b0, Operand1} + {1'b0, Operand2};
      case (Opcode)
         OP_ADD: begin
            alu_res = {{(WIDTH-1){1'b0}}, add_sum};
            alu_c   = add_sum[WIDTH];
         end
         OP_SUB: begin
            alu_res = {{WIDTH{1'b0}}, Operand1 - Operand2};
            alu_c   = (Operand1 < Operand2);
         end
         OP_AND:  alu_res = {{WIDTH{1'b0}}, Operand1 & Operand2};
         OP_OR:   alu_res = {{WIDTH{1'b0}}, Operand1 | Operand2};
         OP_XOR:  alu_res = {{WIDTH{1'b0}}, Operand1 ^ Operand2};
         OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~Operand1};
         default: alu_res = '0;
      endcase
   end

   // acc holds {high, low}. MUL: {partial product, multiplier}, shifted right.
   // DIV: {remainder, quotient/dividend}, shifted left; restoring subtract.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_ge    = (div_shift >= {1'b0, opb_q});
      if (div_ge) begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
      if (op_q == OP_MUL) begin
         step_res = mul_next;
         step_c   = |mul_next[2*WIDTH-1:WIDTH];
      end else begin
         step_res = div_next;
         step_c   = (opb_q == '0);
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d = Opcode;
               if (Opcode == OP_MUL || Opcode == OP_DIV) begin
                  acc_d   = {{WIDTH{1'b0}}, Operand1};
                  opb_d   = Operand2;
                  cnt_d   = '0;
                  state_d = ST_ITER;
               end else begin
                  result_d = alu_res;
                  flag_c_d = alu_c;
                  flag_z_d = (alu_res == '0);
                  state_d  = ST_DONE;
               end
            end
         end
         ST_ITER: begin
            acc_d = step_res;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = step_res;
               flag_c_d = step_c;
               flag_z_d = (step_res == '0);
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
      end
   end

   // in_ready must drop immediately while reset is held, not one edge later.
   assign in_ready  = (state_q == ST_IDLE) && rst_n;
   assign out_valid = (state_q == ST_DONE);
   assign Result    = result_q;
   assign flagC     = flag_c_q;
   assign flagZ     = flag_z_q;

endmodule

// File: tb/tb_alu_seq_handshake.sv
// Bench for alu_seq_handshake: directed WIDTH=8 vector table and corner sequences,
// plus a randomized WIDTH=16 sweep against an arithmetic reference model.
module tb_alu_seq_handshake;

   logic        clk;
   logic        rst_n;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, c8, z8;
   logic [2:0]  opc8;
   logic [7:0]  a8, b8;
   logic [15:0] res8;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, c16, z16;
   logic [2:0]  opc16;
   logic [15:0] a16, b16;
   logic [31:0] res16;

   int checks;
   int failures;

   alu_seq_handshake #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .Opcode(opc8), .Operand1(a8), .Operand2(b8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .Result(res8), .flagC(c8), .flagZ(z8)
   );

   alu_seq_handshake #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .Opcode(opc16), .Operand1(a16), .Operand2(b16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .Result(res16), .flagC(c16), .flagZ(z16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      logic        c;
      logic        z;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: results computed straight from the opcode definitions.
   function automatic void model(input int w, input logic [2:0] op,
                                 input longint unsigned a, input longint unsigned b,
                                 output longint unsigned r, output logic c, output logic z);
      longint unsigned one;
      longint unsigned m;
      one = 1;
      m = (one << w) - 1;
      c = 1'b0;
      r = 0;
      case (op)
         3'd0: begin r = a + b; c = ((r >> w) != 0); end
         3'd1: begin r = (a - b) & m; c = (a < b); end
         3'd2: begin r = a * b; c = ((r >> w) != 0); end
         3'd3: begin
            if (b == 0) begin
               r = (a << w) | m;
               c = 1'b1;
            end else begin
               r = ((a % b) << w) | (a / b);
            end
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = (~a) & m;
      endcase
      z = (r == 0);
   endfunction

   // Issue one op with out_ready high; scramble inputs after accept.
   task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r, output logic c, output logic z,
                       output int lat, output logic ready_ok, output logic hs_ok);
      @(negedge clk);
      in_valid8 = 1'b1; opc8 = op; a8 = a; b8 = b; out_ready8 = 1'b1;
      #1 ready_ok = in_ready8;
      @(negedge clk);
      in_valid8 = 1'b0;
      opc8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1;
      while (!out_valid8 && lat < 40) begin
         if (in_ready8) ready_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      r = res8; c = c8; z = z8;
      @(negedge clk);
      hs_ok = !out_valid8 && in_ready8;
   endtask

   task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] r, output logic c, output logic z, output int lat);
      @(negedge clk);
      in_valid16 = 1'b1; opc16 = op; a16 = a; b16 = b; out_ready16 = 1'b1;
      @(negedge clk);
      in_valid16 = 1'b0;
      opc16 = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 1;
      while (!out_valid16 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      r = res16; c = c16; z = z16;
      @(negedge clk);
   endtask

   function automatic logic [15:0] pick16();
      int k;
      k = $urandom_range(0, 5);
      if (k == 0) return 16'h0000;
      if (k == 1) return 16'hFFFF;
      return 16'($urandom);
   endfunction

   initial begin
      logic [15:0] r8;
      logic [31:0] r16;
      logic        c, z, rok, hok, ec, ez;
      longint unsigned er;
      int          lat, seen;

      checks = 0;
      failures = 0;
      vecs[0]  = '{3'd0, 8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1};
      vecs[1]  = '{3'd1, 8'h55, 8'hAA, 16'h00AB, 1'b1, 1'b0, 1};
      vecs[2]  = '{3'd2, 8'hAA, 8'h55, 16'h3872, 1'b1, 1'b0, 9};
      vecs[3]  = '{3'd3, 8'hAA, 8'h55, 16'h0002, 1'b0, 1'b0, 9};
      vecs[4]  = '{3'd3, 8'hAA, 8'h00, 16'hAAFF, 1'b1, 1'b0, 9};
      vecs[5]  = '{3'd4, 8'hAA, 8'h55, 16'h0000, 1'b0, 1'b1, 1};
      vecs[6]  = '{3'd6, 8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1};
      vecs[7]  = '{3'd7, 8'hAA, 8'h55, 16'h0055, 1'b0, 1'b0, 1};
      vecs[8]  = '{3'd5, 8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1};
      vecs[9]  = '{3'd0, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1};
      vecs[10] = '{3'd0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1};
      vecs[11] = '{3'd1, 8'hAA, 8'hAA, 16'h0000, 1'b0, 1'b1, 1};
      vecs[12] = '{3'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, 9};
      vecs[13] = '{3'd2, 8'h0F, 8'h0F, 16'h00E1, 1'b0, 1'b0, 9};
      vecs[14] = '{3'd3, 8'h07, 8'hFF, 16'h0700, 1'b0, 1'b0, 9};
      vecs[15] = '{3'd3, 8'h00, 8'h00, 16'h00FF, 1'b1, 1'b0, 9};

      rst_n = 1'b0;
      in_valid8 = 1'b1; opc8 = 3'd0; a8 = 8'h12; b8 = 8'h34; out_ready8 = 1'b1;
      in_valid16 = 1'b0; opc16 = 3'd0; a16 = '0; b16 = '0; out_ready16 = 1'b1;

      // Reset state, with in_valid asserted during reset.
      repeat (3) @(negedge clk);
      chk("reset in_ready", {63'd0, in_ready8}, 64'd0);
      chk("reset out_valid", {63'd0, out_valid8}, 64'd0);
      chk("reset result", {48'd0, res8}, 64'd0);
      chk("reset flags", {62'd0, c8, z8}, 64'd0);
      rst_n = 1'b1;
      in_valid8 = 1'b0;
      #1 chk("in_ready after reset", {63'd0, in_ready8}, 64'd1);
      @(negedge clk);
      chk("no op from reset", {63'd0, out_valid8}, 64'd0);

      for (int i = 0; i < 16; i++) begin
         run8(vecs[i].op, vecs[i].a, vecs[i].b, r8, c, z, lat, rok, hok);
         $display("vec%0d op=%0d a=%02h b=%02h -> res=%04h C=%0d Z=%0d lat=%0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, r8, c, z, lat);
         chk($sformatf("vec%0d result", i), {48'd0, r8}, {48'd0, vecs[i].res});
         chk($sformatf("vec%0d flagC", i), {63'd0, c}, {63'd0, vecs[i].c});
         chk($sformatf("vec%0d flagZ", i), {63'd0, z}, {63'd0, vecs[i].z});
         chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("vec%0d in_ready busy", i), {63'd0, rok}, 64'd1);
         chk($sformatf("vec%0d handshake", i), {63'd0, hok}, 64'd1);
      end

      // Backpressure: result frozen, new request held off until after handshake.
      @(negedge clk);
      in_valid8 = 1'b1; opc8 = 3'd6; a8 = 8'hAA; b8 = 8'h55; out_ready8 = 1'b0;
      @(negedge clk);
      opc8 = 3'd0; a8 = 8'h01; b8 = 8'h02;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d result", i), {48'd0, res8}, 64'h00FF);
         chk($sformatf("bp%0d valid/ready", i), {62'd0, out_valid8, in_ready8}, 64'd2);
         chk($sformatf("bp%0d flags", i), {62'd0, c8, z8}, 64'd0);
         @(negedge clk);
      end
      out_ready8 = 1'b1;
      @(negedge clk);
      chk("bp after handshake", {62'd0, out_valid8, in_ready8}, 64'd1);
      @(negedge clk);
      in_valid8 = 1'b0;
      $display("bp next op res=%04h valid=%0d", res8, out_valid8);
      chk("bp next valid", {63'd0, out_valid8}, 64'd1);
      chk("bp next result", {48'd0, res8}, 64'h0003);
      @(negedge clk);
      chk("bp next done", {63'd0, out_valid8}, 64'd0);

      // Reset in the middle of a MUL.
      in_valid8 = 1'b1; opc8 = 3'd2; a8 = 8'hAA; b8 = 8'h55;
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1 chk("mid reset in_ready", {63'd0, in_ready8}, 64'd0);
      @(negedge clk);
      $display("mid reset res=%04h valid=%0d C=%0d Z=%0d", res8, out_valid8, c8, z8);
      chk("mid reset out_valid", {63'd0, out_valid8}, 64'd0);
      chk("mid reset result", {48'd0, res8}, 64'd0);
      chk("mid reset flags", {62'd0, c8, z8}, 64'd0);
      rst_n = 1'b1;
      #1 chk("mid reset release ready", {63'd0, in_ready8}, 64'd1);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid8) seen++;
      end
      chk("no late result", 64'(seen), 64'd0);

      // Randomized WIDTH=16 sweep over all opcodes.
      for (int op = 0; op < 8; op++) begin
         for (int n = 0; n < 25; n++) begin
            logic [15:0] ra, rb;
            ra = pick16();
            rb = pick16();
            model(16, 3'(op), 64'(ra), 64'(rb), er, ec, ez);
            run16(3'(op), ra, rb, r16, c, z, lat);
            $display("w16 op=%0d a=%04h b=%04h -> res=%08h C=%0d Z=%0d lat=%0d",
                     op, ra, rb, r16, c, z, lat);
            chk($sformatf("w16 op%0d result", op), {32'd0, r16}, er);
            chk($sformatf("w16 op%0d flagC", op), {63'd0, c}, {63'd0, ec});
            chk($sformatf("w16 op%0d flagZ", op), {63'd0, z}, {63'd0, ez});
            chk($sformatf("w16 op%0d latency", op), 64'(lat),
                (op == 2 || op == 3) ? 64'd17 : 64'd1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
